// File: rtl/io_bus_controller_if.sv
// CPU I/O port and peripheral slot signals of the TinyComp I/O bus controller.
// The controller takes the slave modport; the CPU/peripheral environment takes master.
interface io_bus_controller_if #(
  parameter int unsigned NSLOTS = 4
);
  logic [3:0]             IOaddr;
  logic                   IOread;
  logic                   IOwrite;
  logic [31:0]            OutValue;
  logic [31:0]            InValue;
  logic                   InReady;
  logic [NSLOTS-1:0]      PerSel;
  logic                   PerRd;
  logic                   PerWr;
  logic [31:0]            PerWdata;
  logic [32*NSLOTS-1:0]   PerRdata;
  logic [NSLOTS-1:0]      PerAck;
  logic [7:0]             Leds;
  logic                   BusError;
  logic [3:0]             ErrAddr;

  modport slave (
    input  IOaddr, IOread, IOwrite, OutValue, PerRdata, PerAck,
    output InValue, InReady, PerSel, PerRd, PerWr, PerWdata, Leds, BusError, ErrAddr
  );

  modport master (
    output IOaddr, IOread, IOwrite, OutValue, PerRdata, PerAck,
    input  InValue, InReady, PerSel, PerRd, PerWr, PerWdata, Leds, BusError, ErrAddr
  );
endinterface

// File: rtl/io_bus_controller.sv
// TinyComp I/O bus controller: address decode, slot sequencing, LED register, timeout/bus-error monitor.
// Optional status register at IOaddr 15 enabled by defining IO_STATUS_REG_EN.
module io_bus_controller #(
  parameter int unsigned NSLOTS   = 4,
  parameter int unsigned LED_ADDR = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input logic                Clock,
  input logic                Reset_n,
  io_bus_controller_if.slave io_bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOCAL, S_ACCESS, S_UNMAPPED, S_STATUS, S_DONE, S_RELEASE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_addr, w_addr_nxt;
  logic               r_dir_wr, w_dir_wr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]        r_in_value, w_in_value_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic [NSLOTS-1:0]  r_sel, w_sel_nxt;
  logic               r_per_rd, w_per_rd_nxt;
  logic               r_per_wr, w_per_wr_nxt;
  logic [31:0]        r_wdata, w_wdata_nxt;
  logic [7:0]         r_leds, w_leds_nxt;
  logic               r_bus_error, w_bus_error_nxt;
  logic [3:0]         r_err_addr, w_err_addr_nxt;
  logic               w_ack;
  logic [31:0]        w_rdata;
`ifdef IO_STATUS_REG_EN
  logic [7:0]         r_acc_cnt, w_acc_cnt_nxt;
`endif

  // Only the selected slot's ack and read data are visible to the FSM
  always_comb begin
    w_ack   = 1'b0;
    w_rdata = '0;
    for (int k = 0; k < int'(NSLOTS); k++) begin
      if (r_sel[k]) begin
        w_ack   = w_ack | io_bus.PerAck[k];
        w_rdata = w_rdata | io_bus.PerRdata[32*k +: 32];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_dir_wr_nxt    = r_dir_wr;
    w_cnt_nxt       = r_cnt;
    w_in_value_nxt  = r_in_value;
    w_sel_nxt       = r_sel;
    w_per_rd_nxt    = r_per_rd;
    w_per_wr_nxt    = r_per_wr;
    w_wdata_nxt     = r_wdata;
    w_leds_nxt      = r_leds;
    w_bus_error_nxt = r_bus_error;
    w_err_addr_nxt  = r_err_addr;
`ifdef IO_STATUS_REG_EN
    w_acc_cnt_nxt   = r_acc_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (io_bus.IOread || io_bus.IOwrite) begin
          w_addr_nxt   = io_bus.IOaddr;
          w_dir_wr_nxt = io_bus.IOwrite && !io_bus.IOread;
          w_wdata_nxt  = io_bus.OutValue;
          w_cnt_nxt    = '0;
          // Simultaneous strobes are serviced as a read but flagged
          if (io_bus.IOread && io_bus.IOwrite) begin
            w_bus_error_nxt = 1'b1;
            if (!r_bus_error) w_err_addr_nxt = io_bus.IOaddr;
          end
`ifdef IO_STATUS_REG_EN
          if (io_bus.IOaddr == 4'd15) w_state_nxt = S_STATUS;
          else
`endif
          if (io_bus.IOaddr == 4'(LED_ADDR)) begin
            w_state_nxt = S_LOCAL;
          end else if (32'(io_bus.IOaddr) < NSLOTS) begin
            w_state_nxt  = S_ACCESS;
            w_sel_nxt    = NSLOTS'(1) << io_bus.IOaddr;
            w_per_rd_nxt = !(io_bus.IOwrite && !io_bus.IOread);
            w_per_wr_nxt = io_bus.IOwrite && !io_bus.IOread;
          end else begin
            w_state_nxt = S_UNMAPPED;
          end
        end
      end
      S_LOCAL: begin
        if (r_dir_wr) w_leds_nxt = r_wdata[7:0];
        else          w_in_value_nxt = {24'b0, r_leds};
        w_state_nxt = S_DONE;
      end
      S_ACCESS: begin
        if (w_ack) begin
          if (!r_dir_wr) w_in_value_nxt = w_rdata;
          w_sel_nxt    = '0;
          w_per_rd_nxt = 1'b0;
          w_per_wr_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_in_value_nxt  = '0;
          w_bus_error_nxt = 1'b1;
          if (!r_bus_error) w_err_addr_nxt = r_addr;
          w_sel_nxt    = '0;
          w_per_rd_nxt = 1'b0;
          w_per_wr_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_UNMAPPED: begin
        w_in_value_nxt  = '0;
        w_bus_error_nxt = 1'b1;
        if (!r_bus_error) w_err_addr_nxt = r_addr;
        w_state_nxt = S_DONE;
      end
`ifdef IO_STATUS_REG_EN
      S_STATUS: begin
        // Status read snapshots and clears the error state; writes are dropped
        if (!r_dir_wr) begin
          w_in_value_nxt  = {16'b0, r_acc_cnt, 3'b0, r_bus_error, r_err_addr};
          w_bus_error_nxt = 1'b0;
          w_err_addr_nxt  = '0;
        end
        w_state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
`ifdef IO_STATUS_REG_EN
        w_acc_cnt_nxt = r_acc_cnt + 8'd1;
`endif
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!io_bus.IOread && !io_bus.IOwrite) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_in_ready_nxt = (w_state_nxt == S_DONE);
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_dir_wr    <= 1'b0;
      r_cnt       <= '0;
      r_in_value  <= '0;
      r_in_ready  <= 1'b0;
      r_sel       <= '0;
      r_per_rd    <= 1'b0;
      r_per_wr    <= 1'b0;
      r_wdata     <= '0;
      r_leds      <= '0;
      r_bus_error <= 1'b0;
      r_err_addr  <= '0;
`ifdef IO_STATUS_REG_EN
      r_acc_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_dir_wr    <= w_dir_wr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_value  <= w_in_value_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_sel       <= w_sel_nxt;
      r_per_rd    <= w_per_rd_nxt;
      r_per_wr    <= w_per_wr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_leds      <= w_leds_nxt;
      r_bus_error <= w_bus_error_nxt;
      r_err_addr  <= w_err_addr_nxt;
`ifdef IO_STATUS_REG_EN
      r_acc_cnt   <= w_acc_cnt_nxt;
`endif
    end
  end

  assign io_bus.InValue  = r_in_value;
  assign io_bus.InReady  = r_in_ready;
  assign io_bus.PerSel   = r_sel;
  assign io_bus.PerRd    = r_per_rd;
  assign io_bus.PerWr    = r_per_wr;
  assign io_bus.PerWdata = r_wdata;
  assign io_bus.Leds     = r_leds;
  assign io_bus.BusError = r_bus_error;
  assign io_bus.ErrAddr  = r_err_addr;

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller: LED register, slot access, timeout, unmapped, strobe hold, reset abort.
// Status-register steps run only when IO_STATUS_REG_EN is defined.
module tb_io_bus_controller;

  localparam int unsigned NSLOTS = 4;

  logic Clock;
  logic Reset_n;
  int   n_assert;
  int   n_fail;
  int   ack_delay;
  int   sel_cyc;
  logic [3:0]  stray_ack;
  int          lat;
  logic [31:0] val;
  logic        rdy_after;
  logic [3:0]  seen_sel;
  logic        seen_rd;
  logic        seen_wr;
  logic [31:0] seen_wdata;
  int          pulses;

  io_bus_controller_if #(.NSLOTS(NSLOTS)) bus ();

  io_bus_controller #(.NSLOTS(NSLOTS), .LED_ADDR(2), .TIMEOUT(255)) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .io_bus (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Peripheral model: selected slot acks ack_delay cycles after PerSel rises
  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)             sel_cyc <= 0;
    else if (bus.PerSel != 0) sel_cyc <= sel_cyc + 1;
    else                      sel_cyc <= 0;
  end
  assign bus.PerAck   = ((ack_delay != 0 && sel_cyc >= ack_delay) ? bus.PerSel : 4'b0) | stray_ack;
  assign bus.PerRdata = {32'h0BAD0003, 32'h0BAD0002, 32'h12345678, 32'hDEAD0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  // One CPU access; lat counts rising edges from the sampling edge to InReady
  task automatic do_access(input logic [3:0] a, input logic rd, input logic wr, input logic [31:0] d);
    @(negedge Clock);
    bus.IOaddr = a; bus.IOread = rd; bus.IOwrite = wr; bus.OutValue = d;
    lat = 0; val = 'x;
    seen_sel = '0; seen_rd = 1'b0; seen_wr = 1'b0; seen_wdata = '0;
    while (lat < 1000) begin
      @(posedge Clock); #1; lat++;
      if (bus.PerSel != 0) begin
        seen_sel = bus.PerSel; seen_rd = bus.PerRd; seen_wr = bus.PerWr; seen_wdata = bus.PerWdata;
      end
      if (bus.InReady) begin val = bus.InValue; break; end
    end
    bus.IOread = 1'b0; bus.IOwrite = 1'b0;
    @(posedge Clock); #1;
    rdy_after = bus.InReady;
    repeat (2) @(posedge Clock);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    ack_delay = 0; stray_ack = '0;
    Reset_n = 1'b0;
    bus.IOaddr = '0; bus.IOread = 1'b0; bus.IOwrite = 1'b0; bus.OutValue = '0;
    repeat (2) @(negedge Clock);
    chk("rst_invalue",  bus.InValue, 32'h0);
    chk("rst_inready",  32'(bus.InReady), 32'h0);
    chk("rst_persel",   32'(bus.PerSel), 32'h0);
    chk("rst_perrdwr",  32'({bus.PerRd, bus.PerWr}), 32'h0);
    chk("rst_perwdata", bus.PerWdata, 32'h0);
    chk("rst_leds",     32'(bus.Leds), 32'h0);
    chk("rst_buserr",   32'({bus.BusError, bus.ErrAddr}), 32'h0);
    Reset_n = 1'b1;

    // LED register write and read-back
    do_access(4'd2, 1'b0, 1'b1, 32'h000000A5);
    chk("led_wr_lat",    32'(lat), 32'd2);
    chk("led_wr_leds",   32'(bus.Leds), 32'hA5);
    chk("led_wr_nosel",  32'(seen_sel), 32'h0);
    chk("led_wr_1pulse", 32'(rdy_after), 32'h0);
    do_access(4'd2, 1'b1, 1'b0, 32'h0);
    chk("led_rd_lat", 32'(lat), 32'd2);
    chk("led_rd_val", val, 32'h000000A5);

    // Slot 1 read, ack three cycles after select
    ack_delay = 3;
    do_access(4'd1, 1'b1, 1'b0, 32'h0);
    chk("s1_rd_val",    val, 32'h12345678);
    chk("s1_rd_lat",    32'(lat), 32'd5);
    chk("s1_rd_sel",    32'(seen_sel), 32'h2);
    chk("s1_rd_rd",     32'(seen_rd), 32'h1);
    chk("s1_rd_selend", 32'(bus.PerSel), 32'h0);
    chk("s1_rd_1pulse", 32'(rdy_after), 32'h0);
    chk("s1_rd_noerr",  32'(bus.BusError), 32'h0);

    // Slot 3 write, immediate ack; InValue keeps the last read
    ack_delay = 1;
    do_access(4'd3, 1'b0, 1'b1, 32'hCAFEF00D);
    chk("s3_wr_lat",   32'(lat), 32'd3);
    chk("s3_wr_sel",   32'(seen_sel), 32'h8);
    chk("s3_wr_wr",    32'({seen_rd, seen_wr}), 32'h1);
    chk("s3_wr_wdata", seen_wdata, 32'hCAFEF00D);
    chk("s3_wr_hold",  val, 32'h12345678);

    // Slot 0 read never acked; a stray ack on slot 3 must be ignored
    ack_delay = 0; stray_ack = 4'b1000;
    do_access(4'd0, 1'b1, 1'b0, 32'h0);
    stray_ack = '0;
    chk("to_lat",     32'(lat), 32'd256);
    chk("to_val",     val, 32'h0);
    chk("to_buserr",  32'(bus.BusError), 32'h1);
    chk("to_erraddr", 32'(bus.ErrAddr), 32'h0);

    // Unmapped reads: first failing address is kept
    do_reset();
    ack_delay = 1;
    do_access(4'd1, 1'b1, 1'b0, 32'h0);
    do_access(4'd9, 1'b1, 1'b0, 32'h0);
    chk("um9_val", val, 32'h0);
    chk("um9_lat", 32'(lat), 32'd2);
    do_access(4'd10, 1'b1, 1'b0, 32'h0);
    chk("um10_val",     val, 32'h0);
    chk("um10_buserr",  32'(bus.BusError), 32'h1);
    chk("um10_erraddr", 32'(bus.ErrAddr), 32'h9);

    // IOread held well past DONE yields a single completion
    @(negedge Clock);
    bus.IOaddr = 4'd2; bus.IOread = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      if (bus.InReady) pulses++;
    end
    bus.IOread = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd1);
    repeat (2) @(posedge Clock);
    do_access(4'd2, 1'b1, 1'b0, 32'h0);
    chk("hold_next_lat", 32'(lat), 32'd2);

    // Both strobes: serviced as a read, error flagged
    do_reset();
    do_access(4'd2, 1'b0, 1'b1, 32'h0000003C);
    do_access(4'd2, 1'b1, 1'b1, 32'h00000055);
    chk("both_val",     val, 32'h0000003C);
    chk("both_leds",    32'(bus.Leds), 32'h3C);
    chk("both_buserr",  32'(bus.BusError), 32'h1);
    chk("both_erraddr", 32'(bus.ErrAddr), 32'h2);

    // Reset asserted mid-access clears everything without a clock edge
    ack_delay = 0;
    @(negedge Clock);
    bus.IOaddr = 4'd0; bus.IOread = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    chk("abort_sel_before", 32'({bus.PerSel, bus.PerRd}), 32'h3);
    Reset_n = 1'b0;
    #1;
    chk("abort_sel",     32'({bus.PerSel, bus.PerRd, bus.PerWr}), 32'h0);
    chk("abort_invalue", bus.InValue, 32'h0);
    chk("abort_leds",    32'(bus.Leds), 32'h0);
    chk("abort_err",     32'({bus.BusError, bus.ErrAddr, bus.InReady}), 32'h0);
    chk("abort_wdata",   bus.PerWdata, 32'h0);
    bus.IOread = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);

`ifdef IO_STATUS_REG_EN
    // Status read reports and clears the first error
    do_access(4'd7, 1'b1, 1'b0, 32'h0);
    do_access(4'd15, 1'b1, 1'b0, 32'h0);
    chk("st_val",      val, 32'h00000117);
    chk("st_cleared",  32'({bus.BusError, bus.ErrAddr}), 32'h0);
`else
    // Without the status register, address 15 is unmapped
    do_access(4'd15, 1'b1, 1'b0, 32'h0);
    chk("a15_val",     val, 32'h0);
    chk("a15_buserr",  32'({bus.BusError, bus.ErrAddr}), 32'h1F);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
